ws_array_drain: RTL and testbench

Output-side collector for the weight-stationary systolic array. It takes the skewed per-column partial sums leaving the bottom row of cells and deskews them into aligned result rows. Each row is buffered in a small FIFO and presented downstream on a valid/ready handshake. It also gives the array a conservative admission signal so that no result wave is lost.

---
 rtl/ws_array_drain.sv | 113 +++++++++++
 tb/tb_ws_array_drain.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_array_drain.sv
// Purpose: deskews skewed per-column sums from the array bottom row into aligned rows, buffered in a FIFO.
// Latency: wave accepted at t is written at the edge ending t+COLS-1; out_valid from t+COLS when the FIFO is empty.
// Backpressure: out_valid/out_ready handshake; in_ready drops once stored plus in-flight rows would fill the FIFO.
module ws_array_drain #(
    parameter int COLS       = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [COLS*ACC_WIDTH-1:0]       col_sum,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [COLS*ACC_WIDTH-1:0]       out_data,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            ovf_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [COLS*ACC_WIDTH-1:0] aligned;
    logic [COLS-2:0]           vsr;
    logic [31:0]               inflight;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [COLS*ACC_WIDTH-1:0] mem [FIFO_DEPTH];

    // Earlier columns wait longer so every column lines up with the last one.
    for (genvar c = 0; c < COLS - 1; c++) begin : g_delay
        logic [ACC_WIDTH-1:0] dl [COLS-1-c];

        // Data-only delay line; contents are qualified by vsr, so no reset is needed.
        always_ff @(posedge clk) begin
            dl[0] <= col_sum[c*ACC_WIDTH +: ACC_WIDTH];
            for (int s = 1; s < COLS - 1 - c; s++) begin
                dl[s] <= dl[s-1];
            end
        end

        assign aligned[c*ACC_WIDTH +: ACC_WIDTH] = dl[COLS-2-c];
    end

    // The last column arrives last and needs no delay.
    assign aligned[(COLS-1)*ACC_WIDTH +: ACC_WIDTH] = col_sum[(COLS-1)*ACC_WIDTH +: ACC_WIDTH];

    // Count waves still travelling through the deskew pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < COLS - 1; i++) begin
            inflight = inflight + 32'(vsr[i]);
        end
    end

    // Admission looks only at registered state, ignoring a same-cycle pop, so a
    // landing wave always finds a free slot.
    assign in_ready  = (32'(level) + inflight) < 32'(FIFO_DEPTH);
    assign accept    = in_valid && in_ready;
    assign push      = vsr[COLS-2];
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Wave-valid pipeline: the accept pulse reaches the last stage when the row is aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsr <= '0;
        end else begin
            vsr[0] <= accept;
            for (int i = 1; i < COLS - 1; i++) begin
                vsr[i] <= vsr[i-1];
            end
        end
    end

    // Row storage; written only when a tracked wave lands.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= aligned;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (in_valid && !in_ready) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws_array_drain.sv
// Purpose: self-checking bench for ws_array_drain using a row scoreboard and a cycle-level occupancy model.
// Latency: checks first-row timing, ordering, admission, overflow and reset behaviour.
// Backpressure: exercises out_ready stalls, conservative in_ready and forced overflow.
module tb_ws_array_drain;

    localparam int COLS  = 4;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int RW    = COLS * W;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [RW-1:0]   col_sum;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   out_data;
    logic [2:0]      level;
    logic            ovf_err;

    ws_array_drain #(.COLS(COLS), .ACC_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .col_sum   (col_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .ovf_err   (ovf_err)
    );

    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc   = 0;
    logic [RW-1:0]   expq [$];
    logic [RW-1:0]   cur_row;
    logic [W-1:0]    cb  [64][COLS];
    bit              cbv [64][COLS];
    logic [COLS-2:0] mpipe;
    int              mlevel;
    bit              mov;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_ready();
        return (mlevel + $countones(mpipe)) < DEPTH;
    endfunction

    function automatic logic [RW-1:0] mkrow(input int k);
        logic [RW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*W +: W] = W'(16 * k + c);
        if (k == 2) r[0 +: W] = 32'h7FFF_FFFF;
        if (k == 5) r[3*W +: W] = 32'h8000_0000;
        return r;
    endfunction

    // One clock cycle: present skewed data, check outputs at negedge, advance the model.
    task automatic step();
        bit acc;
        bit mrdy;
        bit mpush;
        bit mpop;
        int slot;
        slot = cyc % 64;
        for (int c = 0; c < COLS; c++) begin
            col_sum[c*W +: W] = cbv[slot][c] ? cb[slot][c] : W'($urandom);
            cbv[slot][c] = 1'b0;
        end
        @(negedge clk);
        mrdy = model_ready();
        n_cmp++;
        if (in_ready !== mrdy) begin
            n_bad++;
            $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, mrdy);
        end
        n_cmp++;
        if (out_valid !== (mlevel != 0)) begin
            n_bad++;
            $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, mlevel != 0);
        end
        n_cmp++;
        if (level !== 3'(mlevel)) begin
            n_bad++;
            $display("FAIL level cyc=%0d got=%0d want=%0d", cyc, level, mlevel);
        end
        n_cmp++;
        if (ovf_err !== mov) begin
            n_bad++;
            $display("FAIL ovf_err cyc=%0d got=%b want=%b", cyc, ovf_err, mov);
        end
        n_cmp++;
        if (mlevel == 0) begin
            if (out_data !== '0) begin
                n_bad++;
                $display("FAIL out_data_idle cyc=%0d got=%h want=0", cyc, out_data);
            end
        end else if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty cyc=%0d got=%h", cyc, out_data);
        end else if (out_data !== expq[0]) begin
            n_bad++;
            $display("FAIL out_data cyc=%0d got=%h want=%h", cyc, out_data, expq[0]);
        end
        mpop = (mlevel != 0) && out_ready;
        if (mpop && expq.size() != 0) void'(expq.pop_front());
        acc = in_valid && mrdy && !rst;
        if (acc) expq.push_back(cur_row);
        @(posedge clk);
        #1;
        if (rst) begin
            mpipe  = '0;
            mlevel = 0;
            mov    = 1'b0;
            expq.delete();
        end else begin
            mpush  = mpipe[COLS-2];
            mlevel = mlevel + int'(mpush) - int'(mpop);
            mpipe  = {mpipe[COLS-3:0], acc};
            if (in_valid && !mrdy) mov = 1'b1;
        end
        cyc++;
    endtask

    task automatic offer(input logic [RW-1:0] row);
        for (int c = 0; c < COLS; c++) begin
            cb[(cyc + c) % 64][c]  = row[c*W +: W];
            cbv[(cyc + c) % 64][c] = 1'b1;
        end
        cur_row  = row;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!model_ready() && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_ready_timeout got=busy want=ready", name);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while ((mlevel != 0 || mpipe != '0) && n < 100) begin
            step();
            n++;
        end
        step();
        n_cmp++;
        if (n >= 100 || expq.size() != 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drain left=%0d out_valid=%b want 0/0", name, expq.size(), out_valid);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; col_sum = '0;
        mpipe = '0; mlevel = 0; mov = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || level !== 3'd0 || ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values got rdy=%b vld=%b dat=%h lvl=%0d ovf=%b want 1/0/0/0/0",
                     in_ready, out_valid, out_data, level, ovf_err);
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_single_wave();
        logic [RW-1:0] row;
        for (int c = 0; c < COLS; c++) row[c*W +: W] = W'(100 + c);
        while (cyc < 10) step();
        offer(row);
        step(); step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early got=%b want=0", out_valid);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== {32'd103, 32'd102, 32'd101, 32'd100} || level !== 3'd1) begin
            n_bad++;
            $display("FAIL single_row got vld=%b dat=%h lvl=%0d want 1/%h/1", out_valid, out_data, level,
                     {32'd103, 32'd102, 32'd101, 32'd100});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (level !== 3'd0) begin
            n_bad++;
            $display("FAIL single_pop_level got=%0d want=0", level);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_ready("b2b");
            offer(mkrow(k));
        end
        drain("b2b");
    endtask

    task automatic test_backpressure_overflow();
        int acc_n = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (model_ready()) begin
                acc_n++;
                offer(mkrow(20 + i));
            end else begin
                step();
            end
        end
        n_cmp++;
        if (acc_n != 4 || ovf_err !== 1'b0 || level !== 3'd4) begin
            n_bad++;
            $display("FAIL bp_accepts got acc=%0d ovf=%b lvl=%0d want 4/0/4", acc_n, ovf_err, level);
        end
        offer(mkrow(99));
        n_cmp++;
        if (ovf_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got=%b want=1", ovf_err);
        end
        repeat (3) step();
        drain("bp");
        n_cmp++;
        if (ovf_err !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky got ovf=%b rdy=%b want 1/1", ovf_err, in_ready);
        end
    endtask

    task automatic test_push_pop_full();
        int lv;
        int n = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) offer(mkrow(40 + k));
        while (!(mpipe[COLS-2] && mlevel == 3) && n < 20) begin
            step();
            n++;
        end
        lv = int'(level);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (n >= 20 || lv != 3 || level !== 3'(lv)) begin
            n_bad++;
            $display("FAIL pushpop_level got before=%0d after=%0d want 3/3", lv, level);
        end
        step();
        drain("pushpop");
    endtask

    task automatic test_reset_mid_wave();
        out_ready = 1'b0;
        offer(mkrow(60));
        offer(mkrow(61));
        repeat (4) step();
        offer(mkrow(62));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== '0 || ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid got lvl=%0d vld=%b dat=%h ovf=%b want 0/0/0/0", level, out_valid, out_data, ovf_err);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid_ghost cyc=%0d got=%b want=0", cyc, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_wave();
        test_back_to_back();
        test_backpressure_overflow();
        do_reset(1);
        test_push_pop_full();
        test_reset_mid_wave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
